sync_fifo: RTL and testbench

Single-clock, first-word-fall-through FIFO that buffers byte-wide requests between an upstream producer and a consuming controller, such as the I2C master's command/data queue. The head entry is always presented on `rd_data`, so the consumer can inspect it before popping. Full and empty status flags let both sides gate their handshakes.

---
 rtl/sync_fifo.sv | 70 +++++++
 tb/tb_sync_fifo.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; push/pop take effect on the next edge, and the head is visible with 0-cycle fall-through.
// Pushes while full and pops while empty are dropped. Define SYNC_FIFO_CLR_MEM_EN to zero storage on reset.
module sync_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_full,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [AW:0]       count_q, count_d;
   logic              push, pop;

   // Acceptance is gated by the registered flags, so a push at full is lost even when a pop frees a slot.
   assign wr_full  = (count_q == FULL_CNT);
   assign rd_empty = (count_q == '0);
   assign push     = wr_en && !wr_full;
   assign pop      = rd_en && !rd_empty;
   assign rd_data  = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

`ifdef SYNC_FIFO_CLR_MEM_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (push) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end
`else
   // No reset on storage so it can map onto RAM.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wr_data;
   end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo (DATA_W=8, DEPTH=16).
module tb_sync_fifo;

   logic       clk = 1'b0;
   logic       rst;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       wr_full;
   logic       rd_en;
   logic [7:0] rd_data;
   logic       rd_empty;

   int tests_run = 0;
   int tests_failed = 0;

   sync_fifo #(.DATA_W(8), .DEPTH(16)) dut (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .wr_full  (wr_full),
      .rd_en    (rd_en),
      .rd_data  (rd_data),
      .rd_empty (rd_empty)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] d);
      wr_en = 1'b1; wr_data = d; rd_en = 1'b0;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic pop_chk(input string tag, input logic [7:0] exp);
      chk(tag, {24'd0, rd_data}, {24'd0, exp});
      rd_en = 1'b1; wr_en = 1'b0;
      tick();
      rd_en = 1'b0;
   endtask

   initial begin
      rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = 8'h00;
      #2;
      chk("rst_empty", {31'd0, rd_empty}, 32'd1);
      chk("rst_full",  {31'd0, wr_full},  32'd0);
      tick();
      rst = 1'b0;
      tick();
      chk("idle_empty", {31'd0, rd_empty}, 32'd1);
      chk("idle_full",  {31'd0, wr_full},  32'd0);
`ifdef SYNC_FIFO_CLR_MEM_EN
      chk("idle_data", {24'd0, rd_data}, 32'h00);
`endif

      // Fall-through of a single word
      push(8'hA5);
      chk("ft_empty", {31'd0, rd_empty}, 32'd0);
      chk("ft_data",  {24'd0, rd_data},  32'hA5);
      pop_chk("ft_pop_data", 8'hA5);
      chk("ft_empty_after", {31'd0, rd_empty}, 32'd1);

      // Fill to full, drop while full, drain
      for (int i = 1; i <= 16; i++) begin
         push(8'(i));
         chk("fill_full", {31'd0, wr_full}, (i == 16) ? 32'd1 : 32'd0);
      end
      push(8'hFF);
      chk("drop_full", {31'd0, wr_full}, 32'd1);
      for (int i = 1; i <= 16; i++) begin
         pop_chk("drain_data", 8'(i));
         chk("drain_full", {31'd0, wr_full}, 32'd0);
      end
      chk("drain_empty", {31'd0, rd_empty}, 32'd1);

      // Wrap-around: push 3, pop 3, ten times
      for (int r = 0; r < 10; r++) begin
         for (int j = 0; j < 3; j++) push(8'(8'h20 + r * 3 + j));
         chk("wrap_full", {31'd0, wr_full}, 32'd0);
         for (int j = 0; j < 3; j++) pop_chk("wrap_data", 8'(8'h20 + r * 3 + j));
         chk("wrap_empty", {31'd0, rd_empty}, 32'd1);
      end

      // Simultaneous push/pop with 4 stored
      for (int i = 0; i < 4; i++) push(8'(8'h40 + i));
      for (int i = 0; i < 4; i++) begin
         chk("simul_data", {24'd0, rd_data}, 32'(8'h40 + i));
         wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'(8'h50 + i);
         tick();
         wr_en = 1'b0; rd_en = 1'b0;
         chk("simul_empty", {31'd0, rd_empty}, 32'd0);
         chk("simul_full",  {31'd0, wr_full},  32'd0);
      end
      for (int i = 0; i < 4; i++) pop_chk("simul_drain", 8'(8'h50 + i));
      chk("simul_end_empty", {31'd0, rd_empty}, 32'd1);

      // Simultaneous at full: pop only
      for (int i = 0; i < 16; i++) push(8'(8'h60 + i));
      chk("sf_full_before", {31'd0, wr_full}, 32'd1);
      wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'hEE;
      tick();
      wr_en = 1'b0; rd_en = 1'b0;
      chk("sf_full_after", {31'd0, wr_full}, 32'd0);
      for (int i = 1; i < 16; i++) pop_chk("sf_data", 8'(8'h60 + i));
      chk("sf_empty", {31'd0, rd_empty}, 32'd1);

      // Simultaneous at empty: push only
      wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h77;
      tick();
      wr_en = 1'b0; rd_en = 1'b0;
      chk("se_empty", {31'd0, rd_empty}, 32'd0);
      chk("se_data",  {24'd0, rd_data},  32'h77);
      pop_chk("se_pop", 8'h77);
      chk("se_empty_after", {31'd0, rd_empty}, 32'd1);

      // Asynchronous reset mid-operation
      for (int i = 0; i < 5; i++) push(8'(8'h80 + i));
      chk("ar_pre_empty", {31'd0, rd_empty}, 32'd0);
      #2 rst = 1'b1;
      #1;
      chk("ar_empty", {31'd0, rd_empty}, 32'd1);
      chk("ar_full",  {31'd0, wr_full},  32'd0);
      tick();
      rst = 1'b0;
      tick();
      push(8'h3C);
      chk("ar_push_empty", {31'd0, rd_empty}, 32'd0);
      chk("ar_push_data",  {24'd0, rd_data},  32'h3C);
      pop_chk("ar_pop", 8'h3C);
      chk("ar_end_empty", {31'd0, rd_empty}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
